// File: rtl/expr_sig_collector.sv
// Folds 90-bit expression results into a 32-bit CRC-style signature and compares it to a golden value.
// Optional idle-timeout abort is enabled by defining EXPR_SIG_TIMEOUT_EN.
module expr_sig_collector #(
  parameter logic [31:0] SEED  = 32'hFFFFFFFF,
  parameter logic [31:0] POLY  = 32'h04C11DB7,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [31:0]      expected_sig,
  input  logic             in_valid,
  input  logic [89:0]      y_in,
  output logic             in_ready,
  output logic [31:0]      sig,
  output logic [CNT_W-1:0] vec_cnt,
  output logic             done,
  output logic             pass,
  output logic             timeout
);

  // state | meaning: S_IDLE | awaiting start, S_RUN | folding vectors, S_DONE | result held
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_sig;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_num;
  logic [31:0]      r_exp;
  logic             r_pass;

  logic             w_idle_or_done;
  logic             w_start_acc;
  logic             w_hs;
  logic [31:0]      w_fold;
  logic [31:0]      w_sig_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_to_fire;

  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_start_acc    = start && w_idle_or_done;
  assign w_hs           = in_valid && (r_state == S_RUN);
  assign w_fold         = y_in[31:0] ^ y_in[63:32] ^ {6'b0, y_in[89:64]};
  assign w_sig_nxt      = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ w_fold;
  assign w_cnt_nxt      = r_cnt + 1'b1;

`ifdef EXPR_SIG_TIMEOUT_EN
  logic [7:0] r_idle;
  logic       r_timeout;

  // r_idle == 254 during a non-handshake RUN cycle means this is the 255th idle cycle
  assign w_to_fire = (r_state == S_RUN) && !w_hs && (r_idle == 8'd254);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle    <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state != S_RUN) || w_hs) r_idle <= 8'd0;
      else                            r_idle <= r_idle + 8'd1;
      if (w_start_acc)    r_timeout <= 1'b0;
      else if (w_to_fire) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_to_fire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_num   <= '0;
      r_exp   <= 32'h0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_sig <= SEED;
            r_cnt <= '0;
            r_num <= num_vec;
            r_exp <= expected_sig;
            if (num_vec == '0) begin
              r_state <= S_DONE;
              r_pass  <= (SEED == expected_sig);
            end else begin
              r_state <= S_RUN;
              r_pass  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_hs) begin
            r_sig <= w_sig_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == r_num) begin
              r_state <= S_DONE;
              r_pass  <= (w_sig_nxt == r_exp);
            end
          end else if (w_to_fire) begin
            r_state <= S_DONE;
            r_pass  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign sig      = r_sig;
  assign vec_cnt  = r_cnt;
  assign pass     = r_pass;

endmodule

// File: tb/tb_expr_sig_collector.sv
// Directed + randomized bench for expr_sig_collector against a queue-based signature model.
module tb_expr_sig_collector;

  localparam logic [31:0] SEED  = 32'hFFFFFFFF;
  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam int          CNT_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic [31:0]      expected_sig;
  logic             in_valid;
  logic [89:0]      y_in;
  logic             in_ready;
  logic [31:0]      sig;
  logic [CNT_W-1:0] vec_cnt;
  logic             done;
  logic             pass;
  logic             timeout;

  int total = 0;
  int bad   = 0;

  expr_sig_collector #(.SEED(SEED), .POLY(POLY), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
    .expected_sig(expected_sig), .in_valid(in_valid), .y_in(y_in),
    .in_ready(in_ready), .sig(sig), .vec_cnt(vec_cnt), .done(done),
    .pass(pass), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signature as a polynomial division over GF(2): shift, reduce on carry-out, add the folded word.
  function automatic logic [31:0] ref_sig(input logic [89:0] q [$]);
    logic [31:0] s;
    logic [31:0] f;
    s = SEED;
    foreach (q[i]) begin
      f = q[i][31:0] ^ q[i][63:32] ^ 32'(q[i][89:64]);
      s = (s[31] ? ((s << 1) ^ POLY) : (s << 1)) ^ f;
    end
    return s;
  endfunction

  function automatic logic [89:0] rand90();
    return {26'($urandom), $urandom, $urandom};
  endfunction

  // mode 0: in_valid toggles every other cycle; mode 1: random in_valid
  task automatic run_random(input int n, input bit wrong, input int mode, input bit noise, input string tag);
    logic [89:0] ys [$];
    logic [31:0] ref_s;
    logic [31:0] exp_s;
    int idx;
    int cyc;
    bit v;
    ys.delete();
    for (int i = 0; i < n; i++) ys.push_back(rand90());
    ref_s = ref_sig(ys);
    exp_s = wrong ? ~ref_s : ref_s;
    start = 1'b1; num_vec = CNT_W'(n); expected_sig = exp_s;
    tick();
    start = 1'b0;
    chk({tag, "_ready_after_start"}, 64'(in_ready), 64'd1);
    idx = 0; cyc = 0;
    while (idx < n && cyc < 400) begin
      v = (mode == 0) ? cyc[0] : 1'($urandom_range(0, 1));
      in_valid = v;
      y_in = v ? ys[idx] : rand90();
      if (noise) begin
        start = 1'b1; num_vec = 16'd9; expected_sig = $urandom;
      end
      tick();
      if (v) idx++;
      cyc++;
      if (idx < n) chk({tag, "_in_run_not_done"}, 64'(done), 64'd0);
    end
    in_valid = 1'b0; start = 1'b0;
    chk({tag, "_handshakes_within_budget"}, 64'(idx), 64'(n));
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_ready_low"}, 64'(in_ready), 64'd0);
    chk({tag, "_sig"}, 64'(sig), 64'(ref_s));
    chk({tag, "_vec_cnt"}, 64'(vec_cnt), 64'(n));
    chk({tag, "_pass"}, 64'(pass), 64'(!wrong));
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; y_in = rand90();
      tick();
    end
    in_valid = 1'b0;
    chk({tag, "_hold_sig"}, 64'(sig), 64'(ref_s));
    chk({tag, "_hold_cnt"}, 64'(vec_cnt), 64'(n));
    chk({tag, "_hold_done"}, 64'(done), 64'd1);
    chk({tag, "_hold_pass"}, 64'(pass), 64'(!wrong));
  endtask

  initial begin
    logic [89:0] q0 [$];
    int k;
    bit saw_ready;
    rst_n = 1'b0; start = 1'b0; num_vec = '0; expected_sig = 32'h0;
    in_valid = 1'b0; y_in = '0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_sig", 64'(sig), 64'(SEED));
    chk("rst_vec_cnt", 64'(vec_cnt), 64'd0);
    rst_n = 1'b1;
    in_valid = 1'b1; y_in = rand90();
    tick(); tick();
    in_valid = 1'b0;
    chk("idle_valid_ignored_sig", 64'(sig), 64'(SEED));
    chk("idle_valid_ignored_cnt", 64'(vec_cnt), 64'd0);

    // Single zero vector: one shift of the seed, reduced by POLY.
    q0.delete(); q0.push_back(90'd0);
    chk("model_single_zero", 64'(ref_sig(q0)), 64'h0FB3EE249);
    start = 1'b1; num_vec = 16'd1; expected_sig = 32'hFB3EE249;
    tick();
    start = 1'b0;
    chk("one_vec_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b1; y_in = '0;
    tick();
    in_valid = 1'b0;
    chk("one_vec_sig", 64'(sig), 64'h0FB3EE249);
    chk("one_vec_cnt", 64'(vec_cnt), 64'd1);
    chk("one_vec_done", 64'(done), 64'd1);
    chk("one_vec_pass", 64'(pass), 64'd1);

    start = 1'b1; num_vec = 16'd1; expected_sig = 32'h0;
    tick();
    start = 1'b0;
    chk("restart_done_drops", 64'(done), 64'd0);
    in_valid = 1'b1; y_in = '0;
    tick();
    in_valid = 1'b0;
    chk("wrong_exp_done", 64'(done), 64'd1);
    chk("wrong_exp_pass", 64'(pass), 64'd0);

    start = 1'b1; num_vec = 16'd0; expected_sig = 32'hFFFFFFFF;
    saw_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (in_ready) saw_ready = 1'b1;
      tick();
    end
    chk("zero_vec_done", 64'(done), 64'd1);
    chk("zero_vec_pass", 64'(pass), 64'd1);
    chk("zero_vec_sig", 64'(sig), 64'(SEED));
    chk("zero_vec_ready_never", 64'(saw_ready), 64'd0);
    start = 1'b1; num_vec = 16'd0; expected_sig = 32'h12345678;
    tick();
    start = 1'b0;
    chk("zero_vec_bad_pass", 64'(pass), 64'd0);
    chk("zero_vec_bad_done", 64'(done), 64'd1);

    run_random(4, 1'b0, 0, 1'b0, "toggle4");
    run_random(3, 1'b0, 1, 1'b1, "midrun_start");
    for (int r = 0; r < 4; r++) begin
      run_random(int'($urandom_range(1, 7)), 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), "rand_run");
    end

    start = 1'b1; num_vec = 16'd5; expected_sig = $urandom;
    tick();
    start = 1'b0;
    in_valid = 1'b1; y_in = rand90();
    tick(); tick();
    rst_n = 1'b0; y_in = rand90();
    tick();
    in_valid = 1'b0;
    chk("midrst_ready", 64'(in_ready), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_pass", 64'(pass), 64'd0);
    chk("midrst_timeout", 64'(timeout), 64'd0);
    chk("midrst_sig", 64'(sig), 64'(SEED));
    chk("midrst_cnt", 64'(vec_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

`ifdef EXPR_SIG_TIMEOUT_EN
    start = 1'b1; num_vec = 16'd2; expected_sig = $urandom;
    tick();
    start = 1'b0;
    in_valid = 1'b1; y_in = rand90();
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!done && k < 400) begin
      tick();
      k++;
    end
    chk("to_idle_cycles", 64'(k), 64'd255);
    chk("to_done", 64'(done), 64'd1);
    chk("to_timeout", 64'(timeout), 64'd1);
    chk("to_pass", 64'(pass), 64'd0);
    chk("to_cnt", 64'(vec_cnt), 64'd1);
    start = 1'b1; num_vec = 16'd0; expected_sig = SEED;
    tick();
    start = 1'b0;
    chk("to_cleared_on_start", 64'(timeout), 64'd0);
`else
    start = 1'b1; num_vec = 16'd2; expected_sig = $urandom;
    tick();
    start = 1'b0;
    in_valid = 1'b1; y_in = rand90();
    tick();
    in_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      k++;
    end
    chk("no_to_still_run", 64'(in_ready), 64'd1);
    chk("no_to_done", 64'(done), 64'd0);
    chk("no_to_timeout", 64'(timeout), 64'd0);
    chk("no_to_cnt", 64'(vec_cnt), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/expr_sig_collector.md
EXPR_SIG_COLLECTOR -- requirements
Module: expr_sig_collector

Interface
REQ-001 The block SHALL have parameter SEED, default 32'hFFFFFFFF, the signature initial value.
REQ-002 The block SHALL have parameter POLY, default 32'h04C11DB7, the signature feedback polynomial.
REQ-003 The block SHALL have parameter CNT_W, default 16, the vector counter width.
REQ-004 The block SHALL have port clk, input, 1, the sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-006 The block SHALL have port start, input, 1, a run request sampled in IDLE or DONE.
REQ-007 The block SHALL have port num_vec, input, CNT_W, the vector count, latched on start.
REQ-008 The block SHALL have port expected_sig, input, 32, the golden signature, latched on start.
REQ-009 The block SHALL have port in_valid, input, 1, marking the 90-bit expression result as valid.
REQ-010 The block SHALL have port y_in, input, 90, the expression-module output vector.
REQ-011 The block SHALL have port in_ready, output, 1, high only in RUN.
REQ-012 The block SHALL have port sig, output, 32, the current signature register.
REQ-013 The block SHALL have port vec_cnt, output, CNT_W, the count of accepted vectors.
REQ-014 The block SHALL have port done, output, 1, high while in DONE.
REQ-015 The block SHALL have port pass, output, 1, high when the final sig equals the latched expected_sig; valid while done=1.
REQ-016 The block SHALL have port timeout, output, 1, the run-aborted flag.

Function
REQ-017 States SHALL be IDLE, RUN, DONE.
- IDLE/DONE + start=1 with num_vec!=0 -> RUN.
- IDLE/DONE + start=1 with num_vec=0 -> DONE.
REQ-018 On start acceptance: sig<=SEED, vec_cnt<=0, pass<=0, timeout<=0; num_vec and expected_sig are latched.
- For num_vec=0: pass<=(SEED==expected_sig).
REQ-019 A handshake SHALL occur when in_valid&&in_ready; y_in is consumed only on a handshake.
REQ-020 Per handshake, fold f = y_in[31:0]^y_in[63:32]^{6'b0,y_in[89:64]}.
- sig <= ((sig<<1) ^ (sig[31]?POLY:0)) ^ f, on the same edge.
- vec_cnt increments, wrap-free since it is bounded by num_vec.
REQ-021 On the handshake making vec_cnt equal to latched num_vec: state->DONE and pass<=(next sig==expected_sig).
- done is therefore high the cycle after the last handshake.
REQ-022 in_valid without in_ready (IDLE/DONE) SHALL be ignored, with no state change.
REQ-023 start in RUN SHALL be ignored; changes to num_vec/expected_sig mid-run SHALL have no effect.
REQ-024 DONE SHALL hold sig, vec_cnt, pass and timeout stable until the next accepted start.
REQ-025 A start in DONE SHALL restart on that edge; done drops the next cycle (or stays high for num_vec=0).

Reset
REQ-026 On rst_n=0 at a clock edge: state=IDLE, sig=SEED, vec_cnt=0, in_ready=0, done=0, pass=0, timeout=0.
REQ-027 Reset mid-RUN SHALL abandon the run; no handshake occurs on a reset edge.

Configuration
REQ-028 With EXPR_SIG_TIMEOUT_EN defined, an 8-bit idle counter SHALL run in RUN.
- It clears on each handshake.
- At 255 consecutive cycles without a handshake: state->DONE, timeout<=1, pass<=0.
REQ-029 Without EXPR_SIG_TIMEOUT_EN: no idle counter exists, timeout is tied 0, and RUN waits indefinitely.

Verification
REQ-030 Reset, start num_vec=1 expected_sig=32'hFB3EE249, one vector y_in=0 -> sig=32'hFB3EE249, vec_cnt=1, done=1, pass=1 one cycle after the handshake.
REQ-031 start num_vec=0 expected_sig=32'hFFFFFFFF -> done=1 next cycle, pass=1, sig=32'hFFFFFFFF, in_ready never high.
REQ-032 num_vec=4 with in_valid toggling every other cycle -> exactly 4 handshakes, sig matches the reference model, in_valid pulses in DONE change nothing.
REQ-033 Mid-run start with num_vec=9 during a num_vec=3 run -> run ends after 3 vectors; rst_n=0 mid-run -> all outputs return to reset values next edge.
REQ-034 EXPR_SIG_TIMEOUT_EN defined, num_vec=2, one handshake then in_valid=0 -> after 255 idle cycles done=1, timeout=1, pass=0, vec_cnt=1.
REQ-035 Wrong expected_sig (32'h0) with the REQ-030 stimulus -> done=1, pass=0.
